// File: rtl/fc_tile_sequencer.sv
// Tile sequencer for the fully-connected engine: LOAD operands, DRAIN the PE
// pipeline, hold WRITE for the output writer, and repeat for every tile in the job.
module fc_tile_sequencer #(
    parameter int TILING_SIZE = 8,
    parameter int PIPE_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           cfg_num_tiles,
    input  logic [15:0]           cfg_k_len,
    input  logic                  mem_ready,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  acc_clr,
    output logic [2:0]            state,
    output logic [15:0]           counter_tiling,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] DRAIN_LAST = 16'(PIPE_DEPTH - 1);
    localparam logic [15:0] WRITE_LAST = 16'(TILING_SIZE + 1);

    state_t                r_state;
    logic [15:0]           r_tile;
    logic [15:0]           r_k;
    logic [15:0]           r_dwell;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [15:0]           r_num_tiles;
    logic [15:0]           r_k_len;
    logic                  r_acc_clr;

    state_t                w_state_nx;
    logic [15:0]           w_tile_nx;
    logic [15:0]           w_k_nx;
    logic [15:0]           w_dwell_nx;
    logic [ADDR_WIDTH-1:0] w_addr_nx;
    logic [15:0]           w_num_nx;
    logic [15:0]           w_klen_nx;
    logic                  w_rd_en;
    logic                  w_acc_clr_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tile      <= '0;
            r_k         <= '0;
            r_dwell     <= '0;
            r_rd_addr   <= '0;
            r_num_tiles <= '0;
            r_k_len     <= '0;
            r_acc_clr   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_tile      <= w_tile_nx;
            r_k         <= w_k_nx;
            r_dwell     <= w_dwell_nx;
            r_rd_addr   <= w_addr_nx;
            r_num_tiles <= w_num_nx;
            r_k_len     <= w_klen_nx;
            r_acc_clr   <= w_acc_clr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_tile_nx  = r_tile;
        w_k_nx     = r_k;
        w_dwell_nx = r_dwell;
        w_addr_nx  = r_rd_addr;
        w_num_nx   = r_num_tiles;
        w_klen_nx  = r_k_len;
        w_rd_en    = (r_state == S_LOAD) && mem_ready;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_num_nx  = cfg_num_tiles;
                    w_klen_nx = cfg_k_len;
                    // An empty job completes without touching memory.
                    if (cfg_num_tiles == 16'd0 || cfg_k_len == 16'd0) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_LOAD;
                        w_tile_nx  = 16'd1;
                        w_k_nx     = '0;
                        w_addr_nx  = '0;
                    end
                end
            end
            S_LOAD: begin
                if (w_rd_en) begin
                    w_addr_nx = r_rd_addr + ADDR_WIDTH'(1);
                    w_k_nx    = r_k + 16'd1;
                    if (r_k == r_k_len - 16'd1) begin
                        w_state_nx = S_DRAIN;
                        w_dwell_nx = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (r_dwell == DRAIN_LAST) begin
                    w_state_nx = S_WRITE;
                    w_dwell_nx = '0;
                end else begin
                    w_dwell_nx = r_dwell + 16'd1;
                end
            end
            S_WRITE: begin
                if (r_dwell == WRITE_LAST) begin
                    w_dwell_nx = '0;
                    if (r_tile == r_num_tiles) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_LOAD;
                        w_tile_nx  = r_tile + 16'd1;
                        w_k_nx     = '0;
                    end
                end else begin
                    w_dwell_nx = r_dwell + 16'd1;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_tile_nx  = '0;
                w_k_nx     = '0;
                w_dwell_nx = '0;
                w_addr_nx  = '0;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_tile_nx  = '0;
                w_k_nx     = '0;
                w_dwell_nx = '0;
                w_addr_nx  = '0;
            end
        endcase

        // Abort overrides every transition, including illegal-code recovery.
        if (abort && r_state != S_IDLE) begin
            w_state_nx = S_IDLE;
            w_tile_nx  = '0;
            w_k_nx     = '0;
            w_dwell_nx = '0;
            w_addr_nx  = '0;
        end

        w_acc_clr_nx = (w_state_nx == S_LOAD) && (r_state != S_LOAD);
    end

    assign rd_en          = w_rd_en;
    assign rd_addr        = r_rd_addr;
    assign acc_clr        = r_acc_clr;
    assign state          = r_state;
    assign counter_tiling = r_tile;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);

endmodule
